// File: rtl/btn_debouncer_multi.sv
// -----------------------------------------------------------------------------
// btn_debouncer_multi
//
// Multi-channel push-button conditioner. It sits between the raw pad inputs
// and the game FSM. Each channel has its own logic for these stages:
//   1. two-flop synchroniser, with the pad polarity folded into the first flop;
//   2. a saturating stable-count filter. A new level is accepted only after
//      2**CNT_W consecutive cycles that disagree with the current level;
//   3. registered one-cycle press / release strobes, aligned with the level;
//   4. optional hold-to-repeat strobes (REPEAT_EN=1): the first strobe comes
//      RPT_DLY cycles after the press, then one every RPT_PER cycles.
//
// Parameters:
//   N_CH       number of independent channels
//   CNT_W      filter counter width (acceptance after 2**CNT_W mismatches)
//   ACTIVE_LOW 1: pad reads 0 when pressed; 0: pad reads 1 when pressed
//   REPEAT_EN  1: build the repeat logic; 0: btn_repeat is tied to 0
//   RPT_W      repeat counter width
//   RPT_DLY    press-to-first-repeat distance in cycles (1 .. 2**RPT_W-1)
//   RPT_PER    repeat-to-repeat distance in cycles (1 .. RPT_DLY)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (release synchronised upstream)
//   btn_raw      raw asynchronous pad levels, one bit per channel
//   btn_state    debounced level, 1 = pressed
//   btn_press    one-cycle strobe on the edge where btn_state rises
//   btn_release  one-cycle strobe on the edge where btn_state falls
//   btn_repeat   one-cycle auto-repeat strobe while the button is held
// -----------------------------------------------------------------------------
module btn_debouncer_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 19,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit REPEAT_EN  = 1'b0,
  parameter int RPT_W      = 26,
  parameter int RPT_DLY    = 50000000,
  parameter int RPT_PER    = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks. The repeat parameters are checked
  // even when REPEAT_EN=0, so a bad value is caught before anyone enables it.
  // ---------------------------------------------------------------------------
  localparam longint RPT_MAX = (longint'(1) << RPT_W) - 1;

  if (N_CH < 1 || CNT_W < 1) begin : g_bad_size
    $error("btn_debouncer_multi: N_CH and CNT_W must be at least 1");
  end

  if (RPT_DLY < 1 || longint'(RPT_DLY) > RPT_MAX ||
      RPT_PER < 1 || RPT_PER > RPT_DLY) begin : g_bad_rpt
    $error("btn_debouncer_multi: need 1 <= RPT_PER <= RPT_DLY <= 2**RPT_W-1");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser. Polarity is normalised at the first flop, so everything
  // downstream works in "1 = pressed" terms.
  // ---------------------------------------------------------------------------
  localparam logic [N_CH-1:0] POL_MASK = {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0] sync0;
  logic [N_CH-1:0] sync1;

  // NOTE: sequential state uses non-blocking assignments only. Then every flop
  // samples its inputs as they were before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btn_raw ^ POL_MASK;
      sync1 <= sync0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel filter, strobes and optional repeat engine.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    logic [CNT_W-1:0] cnt_q;
    logic             state_q;
    logic             press_q;
    logic             release_q;
    logic             mismatch;
    logic             accept;

    assign mismatch = (sync1[i] != state_q);
    // The 2**CNT_W-th consecutive mismatch is the one that flips the level.
    assign accept   = mismatch && (&cnt_q);

    // NOTE: every counter is cleared by reset, not only the visible outputs.
    // If a reset arrived mid-count, a leftover count would shorten the next
    // acceptance window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (!mismatch) begin
          // Any agreeing cycle restarts the stability window.
          cnt_q <= '0;
        end else begin
          // Natural wrap: the all-ones count rolls over to 0 on the same edge
          // that accepts the new level.
          cnt_q <= cnt_q + 1'b1;
          if (accept) begin
            state_q   <= ~state_q;
            press_q   <= ~state_q;
            release_q <=  state_q;
          end
        end
      end
    end

    assign btn_state[i]   = state_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    if (REPEAT_EN) begin : g_rpt
      typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_PERIOD = 2'd2
      } rpt_state_t;

      localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RPT_DLY - 1);
      localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RPT_PER - 1);

      rpt_state_t       rpt_st;
      logic [RPT_W-1:0] rpt_cnt;
      logic             repeat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rpt_st   <= RPT_IDLE;
          rpt_cnt  <= '0;
          repeat_q <= 1'b0;
        end else begin
          repeat_q <= 1'b0;
          if (accept) begin
            // The filter flips on this edge. A rise arms the delay; a fall
            // aborts at once, so a release edge never carries a repeat.
            rpt_cnt <= '0;
            rpt_st  <= state_q ? RPT_IDLE : RPT_DELAY;
          end else begin
            case (rpt_st)
              RPT_IDLE: begin
                rpt_cnt <= '0;
              end
              RPT_DELAY: begin
                if (rpt_cnt == DLY_LAST) begin
                  repeat_q <= 1'b1;
                  rpt_cnt  <= '0;
                  rpt_st   <= RPT_PERIOD;
                end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
                end
              end
              RPT_PERIOD: begin
                if (rpt_cnt == PER_LAST) begin
                  repeat_q <= 1'b1;
                  rpt_cnt  <= '0;
                end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
                end
              end
              default: begin
                rpt_st  <= RPT_IDLE;
                rpt_cnt <= '0;
              end
            endcase
          end
        end
      end

      assign btn_repeat[i] = repeat_q;
    end else begin : g_no_rpt
      assign btn_repeat[i] = 1'b0;
    end

  end

endmodule

// File: tb/tb_btn_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_btn_debouncer_multi
//
// Bench for btn_debouncer_multi. It uses CNT_W=3 (8-cycle acceptance),
// RPT_DLY=20 and RPT_PER=5. The run has three parts:
//   - a table of directed vectors: reset, clean press, release, simultaneity;
//   - hand-written sequences: bounce rejection, repeat timing, mid-count reset;
//   - a randomized run compared against a sliding-window reference model.
// Every comparison covers the whole output bundle
// {btn_state, btn_press, btn_release, btn_repeat}.
// -----------------------------------------------------------------------------
module tb_btn_debouncer_multi;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 3;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int RPT_W      = 8;
  localparam int RPT_DLY    = 20;
  localparam int RPT_PER    = 5;
  localparam int WIN        = 1 << CNT_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] btn_raw = '0;
  logic [N_CH-1:0] btn_state;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_repeat;

  int n_checks = 0;
  int n_fail   = 0;

  btn_debouncer_multi #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .ACTIVE_LOW(ACTIVE_LOW),
    .REPEAT_EN (1'b1),
    .RPT_W     (RPT_W),
    .RPT_DLY   (RPT_DLY),
    .RPT_PER   (RPT_PER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [4*N_CH-1:0] outs();
    return {btn_state, btn_press, btn_release, btn_repeat};
  endfunction

  task automatic check(input string name, input logic [4*N_CH-1:0] act,
                       input logic [4*N_CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {st,pr,rl,rp}=%h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic do_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string name, input logic [N_CH-1:0] st,
                          input logic [N_CH-1:0] pr, input logic [N_CH-1:0] rl,
                          input logic [N_CH-1:0] rp);
    do_step();
    check(name, outs(), {st, pr, rl, rp});
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A level flips when the last 2**CNT_W samples seen by the
  // filter all disagree with it. Repeats are derived arithmetically from the
  // edge count since the press.
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] m_pipe0, m_pipe1;
  logic [N_CH-1:0] m_state, m_press, m_release, m_repeat;
  logic [WIN-1:0]  m_hist [N_CH];
  int              m_cyc;
  int              m_press_cyc [N_CH];

  task automatic model_reset();
    m_pipe0 = '0; m_pipe1 = '0;
    m_state = '0; m_press = '0; m_release = '0; m_repeat = '0;
    m_cyc = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_hist[ch]      = '0;
      m_press_cyc[ch] = 0;
    end
  endtask

  // Called once per rising edge, with the btn_raw value present at that edge.
  task automatic model_step(input logic [N_CH-1:0] raw);
    logic [N_CH-1:0] seen;
    int d;
    seen    = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = raw ^ {N_CH{ACTIVE_LOW}};
    m_cyc++;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_hist[ch]     = {m_hist[ch][WIN-2:0], seen[ch]};
      m_press[ch]    = 1'b0;
      m_release[ch]  = 1'b0;
      if (m_hist[ch] == {WIN{~m_state[ch]}}) begin
        m_state[ch] = ~m_state[ch];
        if (m_state[ch]) begin
          m_press[ch]     = 1'b1;
          m_press_cyc[ch] = m_cyc;
        end else begin
          m_release[ch] = 1'b1;
        end
      end
      d = m_cyc - m_press_cyc[ch];
      m_repeat[ch] = m_state[ch] && (d >= RPT_DLY) &&
                     (((d - RPT_DLY) % RPT_PER) == 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int              n;
    logic            rst_n;
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] st;
    logic [N_CH-1:0] pr;
    logic [N_CH-1:0] rl;
    logic [N_CH-1:0] rp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic [N_CH-1:0] raw,
                     input logic [N_CH-1:0] st, input logic [N_CH-1:0] pr,
                     input logic [N_CH-1:0] rl, input logic [N_CH-1:0] rp);
    vec_t v;
    v.n = n; v.rst_n = r; v.raw = raw;
    v.st = st; v.pr = pr; v.rl = rl; v.rp = rp;
    vecs.push_back(v);
  endtask

  // Random level generator state
  logic [N_CH-1:0] r_lvl;
  int              r_dur [N_CH];

  initial begin
    // Reset with all pads pressed, then the press appears 10 cycles after release.
    add(3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(9, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    // Release everything.
    add(9, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
    add(1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    // Clean press on ch0.
    add(9, 1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0);
    add(1, 1'b1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0);
    // Release ch0.
    add(9, 1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
    add(2, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    // Simultaneous press on ch0 and ch1, then simultaneous release.
    add(9, 1'b1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hC, 4'h3, 4'h3, 4'h0, 4'h0);
    add(1, 1'b1, 4'hC, 4'h3, 4'h0, 4'h0, 4'h0);
    add(9, 1'b1, 4'hF, 4'h3, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h3, 4'h0);
    add(2, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

    #1;
    check("reset_async", outs(), '0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        rst_n   = vecs[i].rst_n;
        btn_raw = vecs[i].raw;
        step_chk($sformatf("vec%0d.%0d", i, k),
                 vecs[i].st, vecs[i].pr, vecs[i].rl, vecs[i].rp);
      end
    end

    // Bounce on ch1: low 7, high 1, then low and held.
    for (int c = 1; c <= 19; c++) begin
      btn_raw = (c == 8) ? 4'hF : 4'hD;
      step_chk($sformatf("bounce.%0d", c), (c >= 18) ? 4'h2 : 4'h0,
               (c == 18) ? 4'h2 : 4'h0, 4'h0, 4'h0);
    end
    for (int c = 1; c <= 11; c++) begin
      btn_raw = 4'hF;
      step_chk($sformatf("bounce_rel.%0d", c), (c < 10) ? 4'h2 : 4'h0, 4'h0,
               (c == 10) ? 4'h2 : 4'h0, 4'h0);
    end

    // Repeat on ch2. Press at 10, repeats at 30,35,...,55. The release lands
    // at 60, exactly where the next repeat would otherwise fall.
    for (int c = 1; c <= 75; c++) begin
      btn_raw = (c <= 50) ? 4'hB : 4'hF;
      step_chk($sformatf("repeat.%0d", c),
               (c >= 10 && c < 60) ? 4'h4 : 4'h0,
               (c == 10) ? 4'h4 : 4'h0,
               (c == 60) ? 4'h4 : 4'h0,
               (c >= 30 && c < 60 && ((c - 30) % 5) == 0) ? 4'h4 : 4'h0);
    end

    // Reset during the 5th mismatch cycle on ch3; the count restarts afterwards.
    for (int c = 1; c <= 6; c++) begin
      btn_raw = 4'h7;
      step_chk($sformatf("midrst_pre.%0d", c), 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_assert", outs(), '0);
    for (int c = 1; c <= 2; c++) step_chk($sformatf("midrst_hold.%0d", c), 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step_chk($sformatf("midrst_post.%0d", c), (c >= 10) ? 4'h8 : 4'h0,
               (c == 10) ? 4'h8 : 4'h0, 4'h0, 4'h0);
    end
    for (int c = 1; c <= 11; c++) begin
      btn_raw = 4'hF;
      step_chk($sformatf("midrst_rel.%0d", c), (c < 10) ? 4'h8 : 4'h0, 4'h0,
               (c == 10) ? 4'h8 : 4'h0, 4'h0);
    end

    // Randomized run against the reference model, with one reset in the middle.
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) step_chk("rand_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    r_lvl = '1;
    for (int ch = 0; ch < N_CH; ch++) r_dur[ch] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) step_chk("rand_midrst", 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        if (r_dur[ch] == 0) begin
          r_lvl[ch] = 1'($urandom_range(0, 1));
          r_dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                  : int'($urandom_range(1, 12));
        end
        r_dur[ch]--;
      end
      btn_raw = r_lvl;
      do_step();
      model_step(btn_raw);
      check($sformatf("rand.%0d", cyc), outs(),
            {m_state, m_press, m_release, m_repeat});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
